scanline_pair_buffer: RTL and testbench
=======================================

SCANLINE_PAIR_BUFFER -- requirements
Module: scanline_pair_buffer

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, bits per colour channel.
REQ-002 SHALL have parameter ROW_WIDTH, default 2, pixels per scanline.
REQ-003 SHALL have parameter N_LINES, default 2, scanlines per frame block.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port s_pixel, input, 3*BIT_DEPTH, one pixel; colour 0 (red) in the LSBs, then green, then blue (colour 2) in the MSBs.
REQ-007 SHALL have port s_valid, input, 1, s_pixel valid.
REQ-008 SHALL have port s_ready, output, 1, block accepts s_pixel.
REQ-009 SHALL have port s_sof, input, 1, marks the first pixel of a frame; sampled only on an input handshake.
REQ-010 SHALL have port scanline_last, output, packed [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0], previous frame block.
REQ-011 SHALL have port scanline_current, output, same packed type as REQ-010, newest frame block.
REQ-012 SHALL have port m_valid, output, 1, the output pair is valid.
REQ-013 SHALL have port m_ready, input, 1, the downstream interpolator consumes the pair.
REQ-014 SHALL have port sof_err, output, 1, sticky flag for a misplaced s_sof.

Function
REQ-015 SHALL accept a pixel only when s_valid and s_ready are both 1 on the same clk edge (input handshake).
REQ-016 SHALL write accepted pixels in raster order into cur[line][pixel], with pixel index incrementing first, then line.
REQ-017 SHALL keep a write counter of width $clog2(N_LINES*ROW_WIDTH+1) that wraps to 0 after pixel N_LINES*ROW_WIDTH-1 is accepted.
REQ-018 SHALL run a state machine with three states: PRIME (no previous frame held), FILL, and OUT.
REQ-019 In PRIME and FILL, SHALL drive s_ready=1 and m_valid=0.
REQ-020 In PRIME, SHALL on acceptance of the final pixel of a frame copy the completed block to last and move to FILL, producing no output.
REQ-021 In FILL, SHALL on acceptance of the final pixel move to OUT on the next cycle; that final pixel SHALL appear in scanline_current.
REQ-022 In OUT, SHALL drive s_ready=0 and m_valid=1, and SHALL hold scanline_last and scanline_current stable.
REQ-023 In OUT, on an output handshake (m_valid and m_ready both 1), SHALL copy current to last and move to FILL on the same edge.
REQ-024 SHALL keep m_valid high until the handshake completes; m_ready low SHALL back-pressure s_ready indefinitely.
REQ-025 Latency SHALL be m_valid rising exactly 1 cycle after the input handshake of the final pixel of a frame.
REQ-026 SHALL have no more than one input handshake and one output handshake per cycle; the two can never occur in the same cycle, since s_ready=0 in OUT.
REQ-027 SHALL drive scanline_last and scanline_current directly from registers, with no combinational path from s_pixel.

Reset
REQ-028 While resetn=0, SHALL asynchronously set: state=PRIME, counter=0, s_ready=0, m_valid=0, sof_err=0, cur=0, last=0.
REQ-029 SHALL drive s_ready=1 from the first clk edge after resetn deasserts.
REQ-030 A reset asserted mid-frame or during OUT SHALL discard all partial and held data; the next frame re-primes.

Configuration
REQ-031 SHALL use the macro SCANLINE_PAIR_BUFFER_SOF_CHECK_EN to compile the s_sof check in or out.
REQ-032 With SCANLINE_PAIR_BUFFER_SOF_CHECK_EN defined, an accepted pixel with s_sof=1 and counter!=0 SHALL set sof_err=1, which stays set until reset.
REQ-033 With the macro defined, that same pixel SHALL restart the frame: it is stored at [0][0], the counter becomes 1, and the state is unchanged.
REQ-034 With the macro defined, an accepted pixel with counter=0 and s_sof=0 SHALL set sof_err=1, and the pixel SHALL be stored normally.
REQ-035 Without the macro, SHALL ignore s_sof and tie sof_err to 0.

Verification
REQ-036 Reset behaviour: hold resetn=0, then release -> s_ready=0 and m_valid=0 during reset; s_ready=1 one cycle after release.
REQ-037 Priming: stream 4 white pixels (0xFFFFFF), then 4 black pixels (0x000000), with m_ready=1 -> no m_valid during the white frame; m_valid pulses 1 cycle after the 8th pixel with last all 0xFF and current all 0x00.
REQ-038 Colour order: after priming, stream red pixels 0x0000FF -> scanline_current[l][p][0]=255 and [1]=[2]=0 for all l, p.
REQ-039 Back-pressure: hold m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0 and outputs unchanged; raise m_ready -> handshake, then s_ready=1 the next cycle; the new last equals the previous current.
REQ-040 Reset mid-frame: after 2 of 4 pixels, pulse resetn low -> next 4 pixels only prime, with no m_valid.
REQ-041 With SCANLINE_PAIR_BUFFER_SOF_CHECK_EN defined: send s_sof=1 on the 3rd pixel -> sof_err=1 and the frame completes 3 pixels later; without the macro -> sof_err=0 and the frame completes after the 4th pixel.

Source files
------------

// File: rtl/scanline_pair_buffer.sv
// -----------------------------------------------------------------------------
// scanline_pair_buffer
//
// Collects a block of N_LINES x ROW_WIDTH RGB pixels from a valid/ready pixel
// stream and presents it alongside the previously completed block, so that a
// downstream interpolator always sees a (previous, newest) pair of blocks.
//
// The first block after reset only primes the "last" store and produces no
// output. Every later block is presented on scanline_last/scanline_current
// with m_valid. While a pair is presented, the input side is stalled until the
// consumer takes the pair. On that handshake the newest block becomes the
// previous one.
//
// Parameters
//   BIT_DEPTH  bits per colour channel
//   ROW_WIDTH  pixels per scanline
//   N_LINES    scanlines per frame block
//
// Ports
//   clk               single clock, rising edge
//   resetn            asynchronous active-low reset
//   s_pixel           input pixel, red in the LSBs, then green, then blue in the MSBs
//   s_valid/s_ready   input handshake
//   s_sof             start-of-frame marker, sampled only on an input handshake
//   scanline_last     previous frame block, indexed [line][pixel][colour]
//   scanline_current  newest frame block, indexed [line][pixel][colour]
//   m_valid/m_ready   output handshake for the block pair
//   sof_err           sticky flag for a misplaced or missing s_sof
//
// Build option
//   SCANLINE_PAIR_BUFFER_SOF_CHECK_EN  when defined, s_sof is checked against
//   the write position. A misplaced s_sof restarts the frame, and a missing
//   s_sof is only flagged. Both cases set sof_err. When the macro is undefined,
//   s_sof is ignored and sof_err is tied low.
// -----------------------------------------------------------------------------
module scanline_pair_buffer #(
  parameter int BIT_DEPTH = 8,
  parameter int ROW_WIDTH = 2,
  parameter int N_LINES   = 2
) (
  input  logic                                                  clk,
  input  logic                                                  resetn,
  input  logic [3*BIT_DEPTH-1:0]                                s_pixel,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  input  logic                                                  s_sof,
  output logic [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0] scanline_last,
  output logic [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0] scanline_current,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic                                                  sof_err
);

  localparam int TOTAL = N_LINES * ROW_WIDTH;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  typedef logic [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0] block_t;

  // PRIME: no previous block held yet.
  // FILL:  collecting the newest block.
  // OUT:   pair presented and waiting for the consumer.
  typedef enum logic [1:0] {
    PRIME = 2'd0,
    FILL  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  block_t        cur_q, cur_d;
  block_t        last_q, last_d;
  logic          started_q;

  logic          accept;
  logic          sof_restart;
  logic [CW-1:0] wr_idx;
  logic          final_pix;

  // The ready enable goes high on the first clock edge after reset is
  // released. This keeps s_ready low for the whole time reset is asserted and
  // until the first edge after release, even though the FSM already sits in
  // PRIME.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  assign s_ready = started_q && (state_q != OUT);
  assign m_valid = (state_q == OUT);
  assign accept  = s_valid && s_ready;

`ifdef SCANLINE_PAIR_BUFFER_SOF_CHECK_EN
  logic sof_missing;
  logic sof_err_q, sof_err_d;

  // An s_sof in the middle of a frame restarts the frame at [0][0].
  // A first pixel that arrives without s_sof is still stored in its normal
  // position, and only the error flag records it.
  assign sof_restart = s_sof && (cnt_q != '0);
  assign sof_missing = !s_sof && (cnt_q == '0);

  // The error flag is sticky. Only reset clears it.
  always_comb begin
    sof_err_d = sof_err_q;
    if (accept && (sof_restart || sof_missing)) begin
      sof_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sof_err_q <= 1'b0;
    end else begin
      sof_err_q <= sof_err_d;
    end
  end

  assign sof_err = sof_err_q;
`else
  logic unused_sof;

  assign unused_sof  = s_sof;
  assign sof_restart = 1'b0;
  assign sof_err     = 1'b0;
`endif

  // Write position for the pixel on the input port. A frame restart redirects
  // the pixel to the first slot, so the "final pixel" test must use this
  // position and not the raw counter.
  assign wr_idx    = sof_restart ? '0 : cnt_q;
  assign final_pix = (wr_idx == LAST_IDX);

  // Raster-order write into the newest block. A flat-index decoder is used
  // instead of a divide/modulo, so each slot just compares against its own
  // constant position.
  always_comb begin
    cur_d = cur_q;
    if (accept) begin
      for (int l = 0; l < N_LINES; l++) begin
        for (int p = 0; p < ROW_WIDTH; p++) begin
          if (wr_idx == CW'(l * ROW_WIDTH + p)) begin
            cur_d[l][p] = s_pixel;
          end
        end
      end
    end
  end

  // The write counter wraps to zero once the last slot of the block is filled.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = final_pix ? '0 : (wr_idx + CW'(1));
    end
  end

  // Next-state logic and previous-block update.
  // PRIME has no earlier block to pair with. It therefore copies its completed
  // block straight into "last", including the pixel written this cycle (taken
  // from cur_d). In OUT, the pair is stable because s_ready is low, so the
  // copy on the consumer handshake uses the registered block.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      PRIME: begin
        if (accept && final_pix) begin
          last_d  = cur_d;
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept && final_pix) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          last_d  = cur_q;
          state_d = FILL;
        end
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  // State, counter and pixel stores. Reset discards any partial or held data,
  // so the next frame primes again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= PRIME;
      cnt_q   <= '0;
      cur_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
    end
  end

  assign scanline_last    = last_q;
  assign scanline_current = cur_q;

endmodule

// File: tb/tb_scanline_pair_buffer.sv
// -----------------------------------------------------------------------------
// tb_scanline_pair_buffer
//
// Directed bench for scanline_pair_buffer with its default 2x2 block of 8-bit
// RGB pixels. Each expected output pair is pushed into a queue before its
// block is streamed. A monitor pops and compares a pair whenever the DUT
// completes an output handshake. Flag and latency checks run inline in the
// stimulus sequence.
// -----------------------------------------------------------------------------
module tb_scanline_pair_buffer;

  localparam int BD = 8;
  localparam int RW = 2;
  localparam int NL = 2;

  typedef logic [NL-1:0][RW-1:0][2:0][BD-1:0] blk_t;
  typedef struct packed {
    blk_t lastBlk;
    blk_t curBlk;
  } pair_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] s_pixel = '0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        m_ready = 1'b0;
  logic        s_ready;
  logic        m_valid;
  logic        sof_err;
  blk_t        scanline_last;
  blk_t        scanline_current;

  int          total = 0;
  int          bad = 0;
  pair_t       expQ[$];
  pair_t       monExp;
  blk_t        bpBlk;

  scanline_pair_buffer #(
    .BIT_DEPTH(BD),
    .ROW_WIDTH(RW),
    .N_LINES  (NL)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .s_pixel         (s_pixel),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_sof           (s_sof),
    .scanline_last   (scanline_last),
    .scanline_current(scanline_current),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .sof_err         (sof_err)
  );

  // 10-time-unit clock period.
  always #5 clk = ~clk;

  function automatic blk_t fillBlk(input logic [23:0] pix);
    blk_t b;
    for (int l = 0; l < NL; l++) begin
      for (int p = 0; p < RW; p++) begin
        b[l][p] = pix;
      end
    end
    return b;
  endfunction

  function automatic blk_t quadBlk(input logic [23:0] a, input logic [23:0] b,
                                   input logic [23:0] c, input logic [23:0] d);
    blk_t r;
    r[0][0] = a;
    r[0][1] = b;
    r[1][0] = c;
    r[1][1] = d;
    return r;
  endfunction

  task automatic checkOutput(input string name, input blk_t act, input blk_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pushExpected(input blk_t lastBlk, input blk_t curBlk);
    pair_t e;
    e.lastBlk = lastBlk;
    e.curBlk  = curBlk;
    expQ.push_back(e);
  endtask

  // Presents one pixel and returns 1 time unit after the edge that accepted
  // it. Inputs change only just after rising edges, so values read on the
  // falling edge are stable.
  task automatic applyStimulus(input logic [23:0] pix, input logic sof);
    int waitCycles;
    waitCycles = 0;
    s_valid = 1'b1;
    s_pixel = pix;
    s_sof   = sof;
    @(negedge clk);
    while (!s_ready && waitCycles < 50) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: s_ready got %b expected 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Scoreboard monitor: an output handshake will occur on the next rising edge.
  always @(negedge clk) begin
    if (resetn && m_valid && m_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got m_valid=1 expected no pair");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pair_last", scanline_last, monExp.lastBlk);
        checkOutput("pair_current", scanline_current, monExp.curBlk);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and release.
    resetn  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkFlag("reset_s_ready", s_ready, 1'b0);
    checkFlag("reset_m_valid", m_valid, 1'b0);
    checkFlag("reset_sof_err", sof_err, 1'b0);
    checkOutput("reset_last", scanline_last, '0);
    checkOutput("reset_current", scanline_current, '0);
    resetn = 1'b1;
    #1;
    checkFlag("release_s_ready_pre_edge", s_ready, 1'b0);
    @(posedge clk);
    #1;
    checkFlag("release_s_ready_post_edge", s_ready, 1'b1);

    // Priming: a white frame, then a black frame.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(24'hFFFFFF, i == 0);
      checkFlag("prime_m_valid", m_valid, 1'b0);
    end
    pushExpected(fillBlk(24'hFFFFFF), fillBlk(24'h000000));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(24'h000000, i == 0);
      if (i < 3) checkFlag("fill_m_valid_early", m_valid, 1'b0);
    end
    checkFlag("latency_m_valid", m_valid, 1'b1);
    checkFlag("out_s_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    checkFlag("post_handshake_m_valid", m_valid, 1'b0);
    checkFlag("post_handshake_s_ready", s_ready, 1'b1);

    // Colour order: red sits in channel 0.
    pushExpected(fillBlk(24'h000000), fillBlk(24'h0000FF));
    for (int i = 0; i < 4; i++) applyStimulus(24'h0000FF, i == 0);
    checkFlag("red_m_valid", m_valid, 1'b1);
    for (int l = 0; l < NL; l++) begin
      for (int p = 0; p < RW; p++) begin
        checkFlag("red_channels",
                  (scanline_current[l][p][0] == 8'd255) &&
                  (scanline_current[l][p][1] == 8'd0) &&
                  (scanline_current[l][p][2] == 8'd0), 1'b1);
      end
    end
    @(posedge clk);
    #1;

    // Back-pressure: hold the pair for 5 cycles with a pixel waiting.
    m_ready = 1'b0;
    bpBlk = quadBlk(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
    pushExpected(fillBlk(24'h0000FF), bpBlk);
    applyStimulus(24'h112233, 1'b1);
    applyStimulus(24'h445566, 1'b0);
    applyStimulus(24'h778899, 1'b0);
    applyStimulus(24'hAABBCC, 1'b0);
    checkFlag("bp_m_valid", m_valid, 1'b1);
    s_valid = 1'b1;
    s_pixel = 24'h010203;
    s_sof   = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkFlag("bp_hold_s_ready", s_ready, 1'b0);
      checkFlag("bp_hold_m_valid", m_valid, 1'b1);
      checkOutput("bp_hold_current", scanline_current, bpBlk);
      checkOutput("bp_hold_last", scanline_last, fillBlk(24'h0000FF));
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    checkFlag("bp_release_m_valid", m_valid, 1'b0);
    checkFlag("bp_release_s_ready", s_ready, 1'b1);
    checkOutput("bp_release_last", scanline_last, bpBlk);

    // Reset in the middle of a frame discards everything and forces re-priming.
    applyStimulus(24'h123456, 1'b1);
    applyStimulus(24'h123456, 1'b0);
    resetn = 1'b0;
    #1;
    checkOutput("midreset_current", scanline_current, '0);
    checkOutput("midreset_last", scanline_last, '0);
    checkFlag("midreset_s_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(24'h00FF00, i == 0);
      checkFlag("reprime_m_valid", m_valid, 1'b0);
    end
    checkOutput("reprime_last", scanline_last, fillBlk(24'h00FF00));
    checkFlag("pre_sof_err", sof_err, 1'b0);

    // Start-of-frame marker arriving on the third pixel.
`ifdef SCANLINE_PAIR_BUFFER_SOF_CHECK_EN
    pushExpected(fillBlk(24'h00FF00), quadBlk(24'h3, 24'h4, 24'h5, 24'h6));
    applyStimulus(24'h000001, 1'b1);
    applyStimulus(24'h000002, 1'b0);
    applyStimulus(24'h000003, 1'b1);
    checkFlag("sof_err_set", sof_err, 1'b1);
    applyStimulus(24'h000004, 1'b0);
    checkFlag("sof_restart_m_valid_4", m_valid, 1'b0);
    applyStimulus(24'h000005, 1'b0);
    checkFlag("sof_restart_m_valid_5", m_valid, 1'b0);
    applyStimulus(24'h000006, 1'b0);
    checkFlag("sof_complete_m_valid", m_valid, 1'b1);
`else
    pushExpected(fillBlk(24'h00FF00), quadBlk(24'h1, 24'h2, 24'h3, 24'h4));
    applyStimulus(24'h000001, 1'b1);
    applyStimulus(24'h000002, 1'b0);
    applyStimulus(24'h000003, 1'b1);
    checkFlag("sof_err_clear", sof_err, 1'b0);
    applyStimulus(24'h000004, 1'b0);
    checkFlag("sof_complete_m_valid", m_valid, 1'b1);
`endif
    @(posedge clk);
    #1;
    checkFlag("sof_post_m_valid", m_valid, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkFlag("scoreboard_drained", expQ.size() == 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
